// File: rtl/design_05_client.sv
// Initiator that sequences start/result/check transactions against a responder and counts mismatches.
// Optional per-handshake watchdog enabled by defining DESIGN05_CLIENT_TIMEOUT_EN.
module design_05_client #(
  parameter int unsigned       WIDTH   = 9,
  parameter int unsigned       NUM_TXN = 16,
  parameter logic [WIDTH-1:0]  B_SEED  = 9'h0A5,
  parameter int unsigned       TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             go,
  output logic [WIDTH-1:0] start_a,
  output logic [WIDTH-1:0] start_b,
  output logic             EN_start,
  input  logic             RDY_start,
  input  logic [WIDTH-1:0] res_result,
  input  logic             RDY_result,
  output logic             EN_check,
  input  logic [WIDTH-1:0] ch_result,
  input  logic             RDY_check,
  output logic             busy,
  output logic             done,
  output logic [15:0]      txn_count,
  output logic [15:0]      err_count,
  output logic             timeout
);

  typedef enum logic [2:0] {StIdle, StStart, StWaitRes, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [15:0]      txn_q, txn_d, err_q, err_d;

`ifdef DESIGN05_CLIENT_TIMEOUT_EN
  localparam int unsigned WaitW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             tmo_q, tmo_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    busy_d   = busy_q;
    done_d   = done_q;
    txn_d    = txn_q;
    err_d    = err_q;
    EN_start = 1'b0;
    EN_check = 1'b0;
`ifdef DESIGN05_CLIENT_TIMEOUT_EN
    tmo_d    = tmo_q;
    wait_d   = '0;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (go) begin
          state_d = StStart;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          txn_d   = '0;
          err_d   = '0;
          a_d     = '0;
          b_d     = B_SEED;
`ifdef DESIGN05_CLIENT_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      StStart: begin
        EN_start = RDY_start;
        if (RDY_start) state_d = StWaitRes;
      end
      StWaitRes: begin
        if (RDY_result) begin
          res_d   = res_result;
          state_d = StCheck;
        end
      end
      StCheck: begin
        EN_check = RDY_check;
        if (RDY_check) begin
          if (ch_result != res_q && err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (txn_q != 16'hFFFF) txn_d = txn_q + 16'd1;
          if (32'(txn_q) + 32'd1 == NUM_TXN) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StStart;
            // Operand index wraps modulo 2^WIDTH by truncation.
            a_d     = WIDTH'(txn_d);
            b_d     = WIDTH'(txn_d) ^ B_SEED;
          end
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef DESIGN05_CLIENT_TIMEOUT_EN
    // Counter only advances while stalled in a handshake state; any state change clears it.
    if ((state_q inside {StStart, StWaitRes, StCheck}) && state_d == state_q) begin
      if (wait_q >= WaitW'(TIMEOUT - 1)) begin
        state_d = StDone;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        tmo_d   = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      txn_q   <= '0;
      err_q   <= '0;
`ifdef DESIGN05_CLIENT_TIMEOUT_EN
      wait_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      txn_q   <= txn_d;
      err_q   <= err_d;
`ifdef DESIGN05_CLIENT_TIMEOUT_EN
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign start_a   = a_q;
  assign start_b   = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign txn_count = txn_q;
  assign err_count = err_q;
`ifdef DESIGN05_CLIENT_TIMEOUT_EN
  assign timeout   = tmo_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_design_05_client.sv
// Scoreboard bench for design_05_client: expected operands queued per run, checked at each start.
module tb_design_05_client;
  localparam int unsigned W = 9;
  localparam logic [W-1:0] SEED = 9'h0A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, go, go2;
  logic rdy_start, rdy_result, rdy_check;
  logic [W-1:0] start_a, start_b, res_result, ch_result;
  logic en_start, en_check, busy, done, timeout;
  logic [15:0] txn_count, err_count;

  logic [W-1:0] start_a2, start_b2, res2;
  logic en_start2, en_check2, busy2, done2, timeout2;
  logic [15:0] txn_count2, err_count2;

  design_05_client #(.WIDTH(W), .NUM_TXN(16), .B_SEED(SEED), .TIMEOUT(255)) dut (
    .CLK(clk), .RST_N(rst_n), .go(go),
    .start_a(start_a), .start_b(start_b), .EN_start(en_start), .RDY_start(rdy_start),
    .res_result(res_result), .RDY_result(rdy_result),
    .EN_check(en_check), .ch_result(ch_result), .RDY_check(rdy_check),
    .busy(busy), .done(done), .txn_count(txn_count), .err_count(err_count), .timeout(timeout)
  );

  design_05_client #(.WIDTH(W), .NUM_TXN(600), .B_SEED(SEED), .TIMEOUT(255)) dut600 (
    .CLK(clk), .RST_N(rst_n), .go(go2),
    .start_a(start_a2), .start_b(start_b2), .EN_start(en_start2), .RDY_start(1'b1),
    .res_result(res2), .RDY_result(1'b1),
    .EN_check(en_check2), .ch_result(res2), .RDY_check(1'b1),
    .busy(busy2), .done(done2), .txn_count(txn_count2), .err_count(err_count2),
    .timeout(timeout2)
  );
  assign res2 = start_a2 + start_b2;

  // Responder: latches a+b when start fires, optionally corrupts check for one index.
  logic [W-1:0] resp = '0, resp_idx = '0;
  int corrupt_idx = -1;
  always @(posedge clk) if (en_start) begin
    resp     <= start_a + start_b;
    resp_idx <= start_a;
  end
  assign res_result = resp;
  assign ch_result  = (int'(resp_idx) == corrupt_idx) ? (resp ^ 9'h001) : resp;

  int checks = 0, failures = 0;
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [2*W-1:0] sb[$];
  int en_start_n = 0, n2 = 0;

  always @(negedge clk) begin
    if (en_start) begin
      logic [2*W-1:0] e;
      en_start_n++;
      check_val("en_start_rdy", 32'(rdy_start), 1);
      check_val("sb_avail", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val("op_a", 32'(start_a), 32'(e[2*W-1:W]));
        check_val("op_b", 32'(start_b), 32'(e[W-1:0]));
      end
    end
    if (en_start2) begin
      if (n2 == 511) begin
        check_val("a_511", 32'(start_a2), 32'h1FF);
        check_val("b_511", 32'(start_b2), 32'h15A);
      end
      if (n2 == 512) begin
        check_val("a_512_wrap", 32'(start_a2), 0);
        check_val("b_512_wrap", 32'(start_b2), 32'h0A5);
      end
      n2++;
    end
  end

  task automatic push_run(input int n);
    logic [W-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = W'(i);
      sb.push_back({a, a ^ SEED});
    end
  endtask

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  // Waits for done with a cycle budget; mid_go re-pulses go at that cycle to prove it is ignored.
  task automatic wait_done(input int budget, input int mid_go, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      go = (cycles == mid_go);
      @(posedge clk); #1 cycles++;
    end
    go = 1'b0;
    check_val("done_reached", 32'(done), 1);
  endtask

  int cyc, base;

  initial begin
    rst_n = 1'b0; go = 1'b0; go2 = 1'b0;
    rdy_start = 1'b1; rdy_result = 1'b1; rdy_check = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_timeout", 32'(timeout), 0);
    check_val("rst_txn", 32'(txn_count), 0);
    check_val("rst_err", 32'(err_count), 0);
    check_val("rst_a", 32'(start_a), 0);
    check_val("rst_b", 32'(start_b), 0);
    check_val("rst_en_start", 32'(en_start), 0);
    check_val("rst_en_check", 32'(en_check), 0);

    // Full-speed run
    push_run(16); base = en_start_n;
    pulse_go();
    check_val("busy_running", 32'(busy), 1);
    wait_done(1000, -1, cyc);
    check_val("run_cycles", cyc, 48);
    check_val("run_txn", 32'(txn_count), 16);
    check_val("run_err", 32'(err_count), 0);
    check_val("run_en_starts", en_start_n - base, 16);
    check_val("run_busy_end", 32'(busy), 0);
    check_val("run_sb_empty", sb.size(), 0);

    // Corrupted check on txn 3, with a go pulse mid-run
    corrupt_idx = 3;
    push_run(16);
    pulse_go();
    wait_done(1000, 10, cyc);
    check_val("corrupt_cycles", cyc, 48);
    check_val("corrupt_err", 32'(err_count), 1);
    check_val("corrupt_txn", 32'(txn_count), 16);
    corrupt_idx = -1;

    // RDY_start held low for 5 cycles at txn 0
    rdy_start = 1'b0;
    push_run(16); base = en_start_n;
    pulse_go();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_en_start", 32'(en_start), 0);
      check_val("stall_a", 32'(start_a), 0);
      check_val("stall_b", 32'(start_b), 32'h0A5);
    end
    @(posedge clk); #1 rdy_start = 1'b1;
    @(negedge clk);
    check_val("stall_release_en", 32'(en_start), 1);
    @(negedge clk);
    check_val("stall_single_en", 32'(en_start), 0);
    check_val("stall_hold_b", 32'(start_b), 32'h0A5);
    wait_done(1000, -1, cyc);
    check_val("stall_txn", 32'(txn_count), 16);
    check_val("stall_en_starts", en_start_n - base, 16);

    // Reset while in WAIT_RES at txn 7
    push_run(16);
    pulse_go();
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!(en_start && start_a == 9'd7) && cyc < 200);
    check_val("reach_txn7", 32'(start_a), 7);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("abort_en_check", 32'(en_check), 0);
      check_val("abort_en_start", 32'(en_start), 0);
      check_val("abort_busy", 32'(busy), 0);
    end
    check_val("abort_txn", 32'(txn_count), 0);
    check_val("abort_a", 32'(start_a), 0);
    check_val("abort_b", 32'(start_b), 0);
    push_run(16); base = en_start_n;
    pulse_go();
    wait_done(1000, -1, cyc);
    check_val("rerun_cycles", cyc, 48);
    check_val("rerun_txn", 32'(txn_count), 16);
    check_val("rerun_err", 32'(err_count), 0);
    check_val("rerun_en_starts", en_start_n - base, 16);

    // RDY_result stuck low
    rdy_result = 1'b0;
    push_run(1);
    pulse_go();
`ifdef DESIGN05_CLIENT_TIMEOUT_EN
    wait_done(400, -1, cyc);
    check_val("tmo_cycles", cyc, 256);
    check_val("tmo_flag", 32'(timeout), 1);
    check_val("tmo_txn", 32'(txn_count), 0);
    check_val("tmo_busy", 32'(busy), 0);
`else
    repeat (300) @(posedge clk);
    #1;
    check_val("hang_busy", 32'(busy), 1);
    check_val("hang_done", 32'(done), 0);
    check_val("hang_timeout", 32'(timeout), 0);
    check_val("hang_txn", 32'(txn_count), 0);
`endif
    rdy_result = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete();

    // 600-transaction instance: operand index wraps at 512
    @(posedge clk); #1 go2 = 1'b1;
    @(posedge clk); #1 go2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 2500) begin
      @(posedge clk); #1 cyc++;
    end
    check_val("n600_done", 32'(done2), 1);
    check_val("n600_cycles", cyc, 1800);
    check_val("n600_txn", 32'(txn_count2), 600);
    check_val("n600_err", 32'(err_count2), 0);
    check_val("n600_starts", n2, 600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
